as5600_i2c_target: RTL and testbench
====================================

AS5600_I2C_TARGET -- requirements
Module: as5600_i2c_target

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h36, 7-bit target address.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, SCL/SDA synchronizer depth.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 clock  input  1  system clock; SHALL be at least 16x the SCL frequency.
REQ-005 raw_angle  input  12  live angle presented to the bus.
REQ-006 magnet_ok  input  1  reflected in STATUS bit 5.
REQ-007 scl  input  1  I2C clock from the initiator.
REQ-008 sda  inout  1  I2C data; driven only 1'b0 or 1'bz.
REQ-009 conf  output  14  {reg 0x07[5:0], reg 0x08[7:0]}, written by the bus.
REQ-010 busy  output  1  high from a matched address through STOP.
REQ-011 rd_done  output  1  one-clock pulse when a read ends in a NACK.

Function
REQ-012 SCL and SDA SHALL pass through SYNC_STAGES flops; all decisions SHALL use the synchronized values and their registered edge detects.
REQ-013 START SHALL be detected as synchronized SDA falling while SCL is high; STOP as SDA rising while SCL is high.
REQ-014 FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, TX, TX_ACK.
REQ-015 Bits SHALL be sampled on the SCL rising edge; SDA SHALL only change on the SCL falling edge (plus sync latency).
REQ-016 START from any state SHALL go to ADDR and clear the bit counter; STOP from any state SHALL go to IDLE and release SDA within 1 clock.
REQ-017 ADDR: after 8 bits, a match with I2C_ADDR SHALL go to ADDR_ACK and drive SDA low for 1 SCL period; a mismatch SHALL go to IDLE with no ACK.
REQ-018 After ADDR_ACK, R/W=0 SHALL go to PTR and R/W=1 SHALL go to TX.
REQ-019 PTR SHALL load the 8-bit register pointer, then ACK, then go to WDATA.
REQ-020 WDATA SHALL write the byte at the pointer (only 0x07 and 0x08 are writable; other addresses are ACKed and discarded), then ACK and increment the pointer.
REQ-021 Register map: 0x07 conf[13:8] (bits 7:6 read 0); 0x08 conf[7:0]; 0x0B STATUS {2'b0, magnet_ok, 5'b0}; 0x0C {4'b0, angle[11:8]}; 0x0D angle[7:0]; 0x0E and 0x0F mirror 0x0C and 0x0D; all others read 8'h00.
REQ-022 On entry to TX at pointer 0x0C or 0x0E, raw_angle SHALL be snapshotted, so a 2-byte read is coherent even if the input changes mid-transfer.
REQ-023 TX SHALL shift the byte MSB first, driving SDA low for 0 and releasing it for 1.
REQ-024 In TX_ACK SDA SHALL be released: on ACK, increment the pointer and load the next byte; on NACK, pulse rd_done and go to IDLE.
REQ-025 The pointer SHALL be 8 bits and wrap 0xFF to 0x00.
REQ-026 The pointer SHALL persist across transactions, so a read with no preceding write starts at the last pointer.
REQ-027 busy SHALL rise on the clock the address matches and fall on STOP or on a mismatch.

Reset
REQ-028 Reset SHALL set: state IDLE, SDA released (z), pointer 0x00, conf 14'h0, busy 0, rd_done 0, snapshot 0, synchronizers to 1.
REQ-029 Reset asserted mid-transaction SHALL release SDA asynchronously; the next bus activity is ignored until a fresh START.

Structure
REQ-030 A shared package SHALL hold: the FSM state encoding, register address constants (0x07, 0x08, 0x0B to 0x0F), and the default I2C address 7'h36.
REQ-031 One sub-module, i2c_bus_sync, SHALL provide the synchronizers and the START/STOP/SCL-rise/SCL-fall pulses; the FSM and register file stay in the top level.

Verification
REQ-032 Write pointer 0x0C, repeated START, read 2 bytes with ACK then NACK, raw_angle=12'hABC -> bytes 8'h0A, 8'hBC; rd_done pulses once.
REQ-033 raw_angle changes 12'h123 to 12'h456 between byte 1 and byte 2 of a read at 0x0E -> returns 8'h01, 8'h23.
REQ-034 Address 7'h37 -> no ACK (SDA stays high on the 9th clock); busy stays 0; state IDLE.
REQ-035 Write 0x07 with 8'hFF then 8'h5A -> conf=14'h3F5A; read back at 0x07 -> 8'h3F, 8'h5A.
REQ-036 Pointer 0xFF, read 2 bytes -> 8'h00 then the byte at 0x00; pointer then holds 0x01.
REQ-037 STOP issued in the middle of TX bit 4 -> SDA released within 1 clock; next transaction starts cleanly; reset_n pulsed mid-ADDR -> SDA released immediately.

Source files
------------

// File: rtl/as5600_pkg.sv
// Shared definitions for the AS5600-style I2C target: FSM encoding,
// register addresses and the register read map.
package as5600_pkg;

   localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h36;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_ADDR      = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] ST_PTR       = 4'd3;
   localparam logic [3:0] ST_PTR_ACK   = 4'd4;
   localparam logic [3:0] ST_WDATA     = 4'd5;
   localparam logic [3:0] ST_WDATA_ACK = 4'd6;
   localparam logic [3:0] ST_TX        = 4'd7;
   localparam logic [3:0] ST_TX_ACK    = 4'd8;

   localparam logic [7:0] REG_CONF_H      = 8'h07;
   localparam logic [7:0] REG_CONF_L      = 8'h08;
   localparam logic [7:0] REG_STATUS      = 8'h0B;
   localparam logic [7:0] REG_ANGLE_H     = 8'h0C;
   localparam logic [7:0] REG_ANGLE_L     = 8'h0D;
   localparam logic [7:0] REG_ANGLE_H_MIR = 8'h0E;
   localparam logic [7:0] REG_ANGLE_L_MIR = 8'h0F;

   function automatic logic is_angle_high(input logic [7:0] addr);
      return (addr == REG_ANGLE_H) || (addr == REG_ANGLE_H_MIR);
   endfunction

   // angle is the live input for the high-byte addresses and the snapshot otherwise.
   function automatic logic [7:0] reg_read(input logic [7:0]  addr,
                                           input logic [13:0] conf,
                                           input logic        magnet_ok,
                                           input logic [11:0] angle);
      case (addr)
         REG_CONF_H:                      return {2'b00, conf[13:8]};
         REG_CONF_L:                      return conf[7:0];
         REG_STATUS:                      return {2'b00, magnet_ok, 5'b00000};
         REG_ANGLE_H, REG_ANGLE_H_MIR:    return {4'h0, angle[11:8]};
         REG_ANGLE_L, REG_ANGLE_L_MIR:    return angle[7:0];
         default:                         return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/as5600_i2c_target_sync.sv
// i2c_bus_sync: SCL/SDA synchronizers plus START, STOP and SCL edge pulses
// derived from the synchronized lines and their one-clock-delayed copies.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic start_det,
   output logic stop_det,
   output logic scl_rise,
   output logic scl_fall
);

   logic [SYNC_STAGES-1:0] scl_chain;
   logic [SYNC_STAGES-1:0] sda_chain;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // NOTE: synchronizers reset to 1 so an idle bus is not mistaken for a START or edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scl_chain <= '1;
         sda_chain <= '1;
         scl_d     <= 1'b1;
         sda_d     <= 1'b1;
      end else begin
         scl_chain <= (scl_chain << 1) | SYNC_STAGES'(scl);
         sda_chain <= (sda_chain << 1) | SYNC_STAGES'(sda);
         scl_d     <= scl_s;
         sda_d     <= sda_s;
      end
   end

   assign scl_s     = scl_chain[SYNC_STAGES-1];
   assign sda_s     = sda_chain[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/as5600_i2c_target.sv
// I2C target exposing a small AS5600-like register map: angle, status and a
// 14-bit bus-writable configuration word, with an auto-incrementing pointer.
module as5600_i2c_target
   import as5600_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR    = DEFAULT_I2C_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        reset_n,
   input  logic        clock,
   input  logic [11:0] raw_angle,
   input  logic        magnet_ok,
   input  logic        scl,
   inout  wire         sda,
   output logic [13:0] conf,
   output logic        busy,
   output logic        rd_done
);

   logic        sda_s;
   logic        start_det;
   logic        stop_det;
   logic        scl_rise;
   logic        scl_fall;

   logic [3:0]  state;
   logic [3:0]  bit_cnt;
   logic [7:0]  shift_q;
   logic [7:0]  ptr;
   logic [11:0] snap;
   logic        rw;
   logic        sda_oe;

   logic [7:0]  rx_byte;
   logic [7:0]  tx_next;
   logic [7:0]  ptr_inc;
   logic        last_bit;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock     (clock),
      .reset_n   (reset_n),
      .scl       (scl),
      .sda       (sda),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall)
   );

   assign sda      = sda_oe ? 1'b0 : 1'bz;
   assign rx_byte  = {shift_q[6:0], sda_s};
   assign last_bit = (bit_cnt == 4'd7);
   assign ptr_inc  = ptr + 8'd1;
   assign tx_next  = reg_read(ptr, conf, magnet_ok, is_angle_high(ptr) ? raw_angle : snap);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shift_q <= '0;
         ptr     <= '0;
         conf    <= '0;
         snap    <= '0;
         rw      <= 1'b0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         rd_done <= 1'b0;
      end else begin
         rd_done <= 1'b0;
         if (stop_det) begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (start_det) begin
            state   <= ST_ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  shift_q <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (last_bit) begin
                     if (rx_byte[7:1] == I2C_ADDR) begin
                        state <= ST_ADDR_ACK;
                        rw    <= rx_byte[0];
                        busy  <= 1'b1;
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end

               // First SCL fall pulls SDA low for the ACK clock, the second ends it.
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     bit_cnt <= '0;
                     if (state == ST_ADDR_ACK && rw) begin
                        state   <= ST_TX;
                        shift_q <= tx_next;
                        sda_oe  <= ~tx_next[7];
                        if (is_angle_high(ptr)) snap <= raw_angle;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                     end
                  end
               end

               ST_PTR: if (scl_rise) begin
                  shift_q <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (last_bit) begin
                     ptr   <= rx_byte;
                     state <= ST_PTR_ACK;
                  end
               end

               ST_WDATA: if (scl_rise) begin
                  shift_q <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (last_bit) begin
                     if (ptr == REG_CONF_H) conf[13:8] <= rx_byte[5:0];
                     if (ptr == REG_CONF_L) conf[7:0]  <= rx_byte;
                     ptr   <= ptr_inc;
                     state <= ST_WDATA_ACK;
                  end
               end

               ST_TX: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        ptr    <= ptr_inc;
                        state  <= ST_TX_ACK;
                     end else begin
                        shift_q <= {shift_q[6:0], 1'b0};
                        sda_oe  <= ~shift_q[6];
                     end
                  end
               end

               // A fall is only reached here after the initiator ACKed the byte.
               ST_TX_ACK: begin
                  if (scl_rise && sda_s) begin
                     rd_done <= 1'b1;
                     state   <= ST_IDLE;
                  end else if (scl_fall) begin
                     bit_cnt <= '0;
                     state   <= ST_TX;
                     shift_q <= tx_next;
                     sda_oe  <= ~tx_next[7];
                     if (is_angle_high(ptr)) snap <= raw_angle;
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Self-checking bench: bit-banged I2C initiator against a transaction-level
// model of the register map, pointer and angle snapshot.
module tb_as5600_i2c_target;

   localparam int         Q    = 5;      // clocks per quarter SCL period
   localparam logic [6:0] ADDR = 7'h36;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [11:0] raw_angle;
   logic        magnet_ok;
   logic        scl_m;
   logic        sda_low;
   wire         sda;
   logic [13:0] conf;
   logic        busy;
   logic        rd_done;

   int n_checks  = 0;
   int n_fail    = 0;
   int rd_pulses = 0;

   // Model state
   logic [7:0]  m_ptr;
   logic [13:0] m_conf;
   logic [11:0] m_snap;
   logic [7:0]  wq[$];

   pullup (sda);
   assign sda = sda_low ? 1'b0 : 1'bz;

   always #5 clock = ~clock;

   always @(posedge clock) if (rd_done) rd_pulses++;

   as5600_i2c_target #(.I2C_ADDR(ADDR), .SYNC_STAGES(2)) dut (
      .reset_n   (reset_n),
      .clock     (clock),
      .raw_angle (raw_angle),
      .magnet_ok (magnet_ok),
      .scl       (scl_m),
      .sda       (sda),
      .conf      (conf),
      .busy      (busy),
      .rd_done   (rd_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_reg(input logic [7:0] a);
      case (a)
         8'h07:        return {2'b00, m_conf[13:8]};
         8'h08:        return m_conf[7:0];
         8'h0B:        return magnet_ok ? 8'h20 : 8'h00;
         8'h0C, 8'h0E: return {4'h0, m_snap[11:8]};
         8'h0D, 8'h0F: return m_snap[7:0];
         default:      return 8'h00;
      endcase
   endfunction

   task automatic wait_q();
      repeat (Q) @(negedge clock);
   endtask

   task automatic xfer_bit(input logic out, output logic in);
      sda_low = ~out;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      in = sda;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_start();
      if (!scl_m) begin
         sda_low = 1'b0;
         wait_q();
         scl_m = 1'b1;
         wait_q();
      end
      sda_low = 1'b1;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_low = 1'b0;
      wait_q();
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic acked);
      logic dummy, a;
      for (int i = 7; i >= 0; i--) xfer_bit(b[i], dummy);
      xfer_bit(1'b1, a);
      acked = ~a;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic v, dummy;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b1, v);
         d[i] = v;
      end
      xfer_bit(~ack, dummy);
   endtask

   // Sets the pointer and writes every byte queued in wq.
   task automatic wr_txn(input logic [7:0] p, input logic do_stop);
      logic ack;
      i2c_start();
      write_byte({ADDR, 1'b0}, ack);
      check("wr_addr_ack", 32'(ack), 1);
      check("busy_after_match", 32'(busy), 1);
      write_byte(p, ack);
      check("ptr_ack", 32'(ack), 1);
      m_ptr = p;
      foreach (wq[i]) begin
         write_byte(wq[i], ack);
         check($sformatf("wdata_ack@%0h", m_ptr), 32'(ack), 1);
         if (m_ptr == 8'h07) m_conf[13:8] = wq[i][5:0];
         if (m_ptr == 8'h08) m_conf[7:0]  = wq[i];
         m_ptr++;
      end
      check("conf", 32'(conf), 32'(m_conf));
      if (do_stop) begin
         i2c_stop();
         check("busy_after_stop", 32'(busy), 0);
      end
   endtask

   // Reads n bytes (ACK all but the last); optionally changes raw_angle after byte 0.
   task automatic rd_txn(input int n, input logic chg, input logic [11:0] ang2);
      logic       ack;
      logic [7:0] d, exp;
      int         pulses0;
      pulses0 = rd_pulses;
      i2c_start();
      write_byte({ADDR, 1'b1}, ack);
      check("rd_addr_ack", 32'(ack), 1);
      for (int i = 0; i < n; i++) begin
         if (m_ptr == 8'h0C || m_ptr == 8'h0E) m_snap = raw_angle;
         exp = m_reg(m_ptr);
         read_byte(i != n - 1, d);
         check($sformatf("rd_byte@%0h", m_ptr), 32'(d), 32'(exp));
         m_ptr++;
         if (chg && i == 0) raw_angle = ang2;
      end
      i2c_stop();
      check("rd_done_once", 32'(rd_pulses - pulses0), 1);
      check("busy_after_rd_stop", 32'(busy), 0);
   endtask

   initial begin
      logic       ack, v;
      logic [7:0] p;
      logic [7:0] picks[9];

      picks = '{8'h07, 8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'hFE};
      reset_n   = 1'b0;
      raw_angle = 12'h000;
      magnet_ok = 1'b0;
      scl_m     = 1'b1;
      sda_low   = 1'b0;
      m_ptr     = 8'h00;
      m_conf    = 14'h0;
      m_snap    = 12'h0;
      repeat (4) @(negedge clock);
      check("rst_sda", 32'(sda), 1);
      check("rst_conf", 32'(conf), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rd_done", 32'(rd_done), 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      // Reset pointer is 0x00
      rd_txn(1, 1'b0, 12'h0);

      // Pointer 0x0C, repeated START, 2-byte read
      raw_angle = 12'hABC;
      wq.delete();
      wr_txn(8'h0C, 1'b0);
      rd_txn(2, 1'b0, 12'h0);

      // Angle changes between the two bytes of a mirror read
      raw_angle = 12'h123;
      wr_txn(8'h0E, 1'b0);
      rd_txn(2, 1'b1, 12'h456);

      // Wrong address: no ACK, not busy, stays idle
      i2c_start();
      write_byte({7'h37, 1'b0}, ack);
      check("bad_addr_nack", 32'(ack), 0);
      check("bad_addr_busy", 32'(busy), 0);
      write_byte(8'hA5, ack);
      check("idle_after_mismatch", 32'(ack), 0);
      i2c_stop();

      // Write conf then read it back
      wq = '{8'hFF, 8'h5A};
      wr_txn(8'h07, 1'b1);
      wq.delete();
      wr_txn(8'h07, 1'b0);
      rd_txn(2, 1'b0, 12'h0);

      // Pointer wrap, then persistence through to 0x07
      wr_txn(8'hFF, 1'b1);
      rd_txn(2, 1'b0, 12'h0);
      rd_txn(7, 1'b0, 12'h0);

      // STOP during a released TX bit (0x3F: 4th bit is a 1)
      wr_txn(8'h07, 1'b0);
      i2c_start();
      write_byte({ADDR, 1'b1}, ack);
      check("abort_addr_ack", 32'(ack), 1);
      for (int i = 0; i < 3; i++) begin
         xfer_bit(1'b1, v);
         check($sformatf("abort_bit%0d", i), 32'(v), (i == 2) ? 1 : 0);
      end
      sda_low = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_low = 1'b0;
      repeat (5) @(negedge clock);
      check("abort_sda_released", 32'(sda), 1);
      check("abort_busy", 32'(busy), 0);
      wait_q();
      wr_txn(8'h08, 1'b0);
      rd_txn(1, 1'b0, 12'h0);

      // Reset while the target drives the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) xfer_bit(((i == 0) ? 1'b0 : ADDR[(i > 0) ? i - 1 : 0]), v);
      sda_low = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      check("ack_driven_before_reset", 32'(sda), 0);
      reset_n = 1'b0;
      #1;
      check("reset_releases_sda", 32'(sda), 1);
      check("reset_clears_conf", 32'(conf), 0);
      check("reset_clears_busy", 32'(busy), 0);
      wait_q();
      scl_m = 1'b0;
      wait_q();
      reset_n = 1'b1;
      m_ptr  = 8'h00;
      m_conf = 14'h0;
      m_snap = 12'h0;
      write_byte({ADDR, 1'b0}, ack);
      check("ignored_without_start", 32'(ack), 0);
      i2c_stop();
      wr_txn(8'h07, 1'b0);
      rd_txn(2, 1'b0, 12'h0);

      // Randomized transactions against the model
      for (int it = 0; it < 12; it++) begin
         raw_angle = 12'($urandom);
         magnet_ok = 1'($urandom);
         p = picks[$urandom_range(0, 8)];
         wq.delete();
         case ($urandom_range(0, 2))
            0: begin
               for (int k = 0; k < int'($urandom_range(1, 2)); k++) wq.push_back(8'($urandom));
               wr_txn(p, 1'b1);
            end
            1: rd_txn(int'($urandom_range(1, 3)), 1'b0, 12'h0);
            default: begin
               wr_txn(p, 1'b0);
               rd_txn(int'($urandom_range(1, 3)), 1'b0, 12'h0);
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
